// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types, defaults and width helpers for the deserializer
package deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_GAP_MAX = 4;

  // Bit counter only ever holds 0..WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  // Gap timer holds 0..GAP_MAX.
  function automatic int gap_w(input int gap_max);
    return $clog2(gap_max + 1);
  endfunction

endpackage

// File: rtl/deser_out_stage.sv
// rtl/deser_out_stage.sv - single-entry holding register with valid/ready and sticky overrun
module deser_out_stage #(
  parameter int WIDTH = deser_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word,
  input  logic             word_done,
  input  logic             clear,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             overrun
);

  // A completing word wins the slot whenever the current one leaves on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (word_done) begin
      if (!out_valid || out_ready) begin
        out       <= word;
        out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - MSB-first serial-to-parallel receiver with gap timeout
module deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int GAP_MAX = DEF_GAP_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_en,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = cnt_w(WIDTH);
  localparam int GW = gap_w(GAP_MAX);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [GW-1:0]    gap, gap_nxt;
  logic [WIDTH-2:0] shreg, shreg_nxt;
  logic             ferr_nxt;
  logic             word_done;
  logic [WIDTH-1:0] word;

  // Bits enter at the LSB, so the first bit received ends up as the word MSB.
  assign word = {shreg, in};
  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gap       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gap       <= gap_nxt;
      shreg     <= shreg_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gap_nxt   = gap;
    shreg_nxt = shreg;
    ferr_nxt  = 1'b0;
    word_done = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      gap_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_en) begin
            shreg_nxt = word[WIDTH-2:0];
            cnt_nxt   = CW'(1);
            gap_nxt   = '0;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (in_en) begin
            gap_nxt = '0;
            if (cnt == CW'(WIDTH - 1)) begin
              word_done = 1'b1;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              shreg_nxt = word[WIDTH-2:0];
              cnt_nxt   = cnt + 1'b1;
            end
          end else if (gap == GW'(GAP_MAX - 1)) begin
            // This idle cycle is the GAP_MAX-th in a row: abandon the partial word.
            ferr_nxt  = 1'b1;
            gap_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            gap_nxt = gap + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  deser_out_stage #(.WIDTH(WIDTH)) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .word      (word),
    .word_done (word_done),
    .clear     (clear),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed, table-driven bench for the deserializer
module tb_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in = 1'b0;
  logic       in_en = 1'b0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out;
  logic       out_valid, busy, overrun, frame_err;

  int checks = 0;
  int errors = 0;

  // seq[i] is the i-th bit on the wire; exp is the word that must appear.
  typedef struct {
    logic [7:0] seq;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  deserializer #(.WIDTH(8), .GAP_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_en     (in_en),
    .clear     (clear),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    in    = b;
    in_en = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    in_en = 1'b0;
    in    = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] seq);
    for (int i = 0; i < 8; i++) drive_bit(seq[i]);
    in_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [15:0] bb;
    logic [7:0]  w;

    vecs[0] = '{8'h76, 8'h6E};
    vecs[1] = '{8'hD9, 8'h9B};
    vecs[2] = '{8'h80, 8'h01};
    vecs[3] = '{8'h01, 8'h80};
    vecs[4] = '{8'hFF, 8'hFF};
    vecs[5] = '{8'hA5, 8'hA5};

    tick();
    tick();
    check("rst out", out, 8'h00);
    check("rst out_valid", out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst overrun", overrun, 1'b0);
    check("rst frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single words, consumer always ready
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) begin
        drive_bit(vecs[v].seq[i]);
        if (i < 7) begin
          check($sformatf("vec%0d busy bit%0d", v, i), busy, 1'b1);
          check($sformatf("vec%0d valid bit%0d", v, i), out_valid, 1'b0);
        end else begin
          check($sformatf("vec%0d out", v), out, vecs[v].exp);
          check($sformatf("vec%0d valid", v), out_valid, 1'b1);
          check($sformatf("vec%0d busy end", v), busy, 1'b0);
          check($sformatf("vec%0d overrun", v), overrun, 1'b0);
        end
      end
      idle(1);
      check($sformatf("vec%0d consumed", v), out_valid, 1'b0);
      check($sformatf("vec%0d held", v), out, vecs[v].exp);
    end

    // Back-to-back words on 16 consecutive in_en cycles
    bb = {8'hD9, 8'h76};
    for (int i = 0; i < 16; i++) begin
      drive_bit(bb[i]);
      check($sformatf("b2b valid c%0d", i), out_valid, (i == 7 || i == 15));
      check($sformatf("b2b busy c%0d", i), busy, !(i == 7 || i == 15));
      if (i == 7)  check("b2b word1", out, 8'h6E);
      if (i == 15) check("b2b word2", out, 8'h9B);
    end
    idle(1);
    check("b2b overrun", overrun, 1'b0);

    // Overrun under backpressure
    out_ready = 1'b0;
    send(8'h76);
    send(8'hD9);
    check("ovr out kept", out, 8'h6E);
    check("ovr valid", out_valid, 1'b1);
    check("ovr flag", overrun, 1'b1);
    out_ready = 1'b1;
    tick();
    check("ovr drained valid", out_valid, 1'b0);
    check("ovr sticky", overrun, 1'b1);
    check("ovr out held", out, 8'h6E);
    out_ready = 1'b0;
    do_clear();
    check("ovr cleared", overrun, 1'b0);

    // Ready on the exact edge the second word completes
    send(8'h76);
    check("sim word1 valid", out_valid, 1'b1);
    check("sim word1 out", out, 8'h6E);
    w = 8'hD9;
    for (int i = 0; i < 8; i++) begin
      out_ready = (i == 7);
      drive_bit(w[i]);
    end
    check("sim out", out, 8'h9B);
    check("sim valid", out_valid, 1'b1);
    check("sim overrun", overrun, 1'b0);
    out_ready = 1'b1;
    idle(1);
    check("sim consumed", out_valid, 1'b0);

    // Gap timeout after 3 bits
    w = 8'hA5;
    for (int i = 0; i < 3; i++) drive_bit(w[i]);
    in_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("gap frame_err g%0d", k), frame_err, (k == 3));
      check($sformatf("gap busy g%0d", k), busy, (k != 3));
    end
    check("gap no valid", out_valid, 1'b0);
    tick();
    check("gap pulse ends", frame_err, 1'b0);
    send(8'hA5);
    check("gap next out", out, 8'hA5);
    check("gap next valid", out_valid, 1'b1);
    idle(1);

    // GAP_MAX-1 idle cycles are tolerated mid-word
    w = 8'h76;
    for (int i = 0; i < 3; i++) drive_bit(w[i]);
    idle(3);
    check("gap3 busy", busy, 1'b1);
    check("gap3 no frame_err", frame_err, 1'b0);
    for (int i = 3; i < 8; i++) drive_bit(w[i]);
    check("gap3 out", out, 8'h6E);
    check("gap3 valid", out_valid, 1'b1);
    idle(1);

    // Asynchronous reset mid-word
    w = 8'hD9;
    for (int i = 0; i < 5; i++) drive_bit(w[i]);
    in_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("amid busy", busy, 1'b0);
    check("amid out", out, 8'h00);
    check("amid valid", out_valid, 1'b0);
    check("amid overrun", overrun, 1'b0);
    check("amid frame_err", frame_err, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b0;
    send(8'h76);
    check("post rst out", out, 8'h6E);
    check("post rst valid", out_valid, 1'b1);
    send(8'hD9);
    check("pre clear overrun", overrun, 1'b1);
    do_clear();
    check("clear valid", out_valid, 1'b0);
    check("clear overrun", overrun, 1'b0);
    check("clear keeps out", out, 8'h6E);

    // Clear drops a partial word
    w = 8'h80;
    for (int i = 0; i < 4; i++) drive_bit(w[i]);
    in_en = 1'b0;
    do_clear();
    check("clear mid busy", busy, 1'b0);
    out_ready = 1'b1;
    send(8'hD9);
    check("after clear out", out, 8'h9B);
    check("after clear valid", out_valid, 1'b1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
